// File: rtl/alu_issue_if.sv
// alu_issue_if: fetch/RF/execute/writeback signals of the ALU issue stage
interface alu_issue_if #(parameter int bitWidth = 32);
  logic                flush_i;
  logic                instr_valid_i;
  logic [31:0]         instr_i;
  logic                instr_ready_o;
  logic [4:0]          rs1_adr_o;
  logic [4:0]          rs2_adr_o;
  logic [bitWidth-1:0] rs1_rf_data_i;
  logic [bitWidth-1:0] rs2_rf_data_i;
  logic                issue_valid_o;
  logic                issue_ready_i;
  logic [bitWidth-1:0] rs1_data_o;
  logic [bitWidth-1:0] rs2_data_o;
  logic                cin_o;
  logic [1:0]          cmd_o;
  logic [4:0]          rd_adr_o;
  logic                illegal_o;
  logic                wb_valid_i;
  logic [4:0]          wb_adr_i;
  modport slave (
    input  flush_i, instr_valid_i, instr_i, rs1_rf_data_i, rs2_rf_data_i, issue_ready_i, wb_valid_i, wb_adr_i,
    output instr_ready_o, rs1_adr_o, rs2_adr_o, issue_valid_o, rs1_data_o, rs2_data_o, cin_o, cmd_o, rd_adr_o, illegal_o
  );
  modport master (
    output flush_i, instr_valid_i, instr_i, rs1_rf_data_i, rs2_rf_data_i, issue_ready_i, wb_valid_i, wb_adr_i,
    input  instr_ready_o, rs1_adr_o, rs2_adr_o, issue_valid_o, rs1_data_o, rs2_data_o, cin_o, cmd_o, rd_adr_o, illegal_o
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU-class decode/issue with busy-bit scoreboard and one-entry output register
module alu_issue #(parameter int bitWidth = 32) (
  input logic         clk_i,
  input logic         reset_n_i,
  alu_issue_if.slave  bus
);
  logic [6:0]          op, f7;
  logic [2:0]          f3;
  logic [4:0]          rs1, rs2, rd;
  logic                r_ok, i_ok, lui, legal, stall, accept;
  logic [31:0]         busy_q, busy_d, busy_eff, clr, set;
  logic                valid_q, valid_d, illegal_q, illegal_d, cin_q, cin_d;
  logic [bitWidth-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [4:0]          rd_q, rd_d;
  assign op  = bus.instr_i[6:0];
  assign rd  = bus.instr_i[11:7];
  assign f3  = bus.instr_i[14:12];
  assign rs1 = bus.instr_i[19:15];
  assign rs2 = bus.instr_i[24:20];
  assign f7  = bus.instr_i[31:25];
  always_comb begin
    r_ok   = op == 7'b0110011 && ((f7 == 7'b0 && (f3 == 3'b000 || f3[2])) && f3 != 3'b101
             || f7 == 7'b0100000 && f3 == 3'b000);
    i_ok   = op == 7'b0010011 && (f3 == 3'b000 || f3[2]) && f3 != 3'b101;
    lui    = op == 7'b0110111;
    legal  = r_ok | i_ok | lui;
    clr    = bus.wb_valid_i ? 32'b1 << bus.wb_adr_i : 32'b0;
    // writeback frees its register in the same cycle so the dependent can issue immediately
    busy_eff = busy_q & ~clr;
    stall  = ((r_ok | i_ok) & busy_eff[rs1]) | (r_ok & busy_eff[rs2]) | (legal & busy_eff[rd]);
    bus.instr_ready_o = !bus.flush_i & !stall & (!valid_q | bus.issue_ready_i);
    accept = bus.instr_valid_i & bus.instr_ready_o;
    set    = accept & legal ? 32'b1 << rd : 32'b0;
    busy_d = bus.flush_i ? 32'b0 : (busy_q & ~clr) | set;
    busy_d[0] = 1'b0;
    valid_d   = bus.flush_i ? 1'b0 : accept & legal ? 1'b1 : valid_q & !bus.issue_ready_i;
    illegal_d = accept & !legal;
    a_d   = accept & legal ? (lui ? '0 : bus.rs1_rf_data_i) : a_q;
    b_d   = !(accept & legal) ? b_q :
            lui  ? bitWidth'($signed({bus.instr_i[31:12], 12'b0})) :
            i_ok ? bitWidth'($signed(bus.instr_i[31:20])) :
            f7[5] ? ~bus.rs2_rf_data_i : bus.rs2_rf_data_i;
    cin_d = accept & legal ? r_ok & f7[5] : cin_q;
    cmd_d = !(accept & legal) ? cmd_q : lui ? 2'b00 :
            f3 == 3'b111 ? 2'b01 : f3 == 3'b110 ? 2'b10 : f3 == 3'b100 ? 2'b11 : 2'b00;
    rd_d  = accept & legal ? rd : rd_q;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      busy_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      cmd_q     <= 2'b00;
      rd_q      <= 5'd0;
    end else begin
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      cmd_q     <= cmd_d;
      rd_q      <= rd_d;
    end
  end
  assign bus.rs1_adr_o     = rs1;
  assign bus.rs2_adr_o     = rs2;
  assign bus.issue_valid_o = valid_q;
  assign bus.illegal_o     = illegal_q;
  assign bus.rs1_data_o    = a_q;
  assign bus.rs2_data_o    = b_q;
  assign bus.cin_o         = cin_q;
  assign bus.cmd_o         = cmd_q;
  assign bus.rd_adr_o      = rd_q;
endmodule
